pcie_lane_deskew: RTL and testbench

//  Receive-side lane deskew stage. Sits between the per-lane link bus driven by the host model
//    (LinkOut0..15, concatenated lane0 in bits [9:0]) and the endpoint's LinkIn ports.

---
 rtl/pcie_lane_pkg.sv | 15 +
 rtl/pcie_lane_fifo.sv | 39 +++
 rtl/pcie_lane_deskew.sv | 145 ++++++++++++++
 tb/tb_pcie_lane_deskew.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_lane_pkg.sv
// Shared symbol constants, deskew FSM states and COM detection for the lane deskew stage.
package pcie_lane_pkg;

  localparam int SYM_W = 10;
  localparam int K_BIT = 8;
  localparam logic [K_BIT:0] COM_SYM = 9'h1BC;

  typedef enum logic [1:0] {SEARCH, WINDOW, ALIGNED} deskewState_t;

  // Bit 9 is always 0 in PIPE mode, so only the K flag and byte are inspected.
  function automatic logic is_com(input logic [K_BIT:0] sym);
    return sym == COM_SYM;
  endfunction

endpackage

// File: rtl/pcie_lane_fifo.sv
// One lane's circular symbol buffer: shared write pointer from the top level,
// private read pointer that can be loaded with a COM address and then advanced.
module pcie_lane_fifo
  import pcie_lane_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [$clog2(DEPTH)-1:0] WrPtr,
  input  logic [SYM_W-1:0]         WrData,
  input  logic                     RdLoad,
  input  logic [$clog2(DEPTH)-1:0] RdLoadPtr,
  input  logic                     RdAdv,
  output logic [SYM_W-1:0]         RdData
);

  localparam int AW = $clog2(DEPTH);

  logic [SYM_W-1:0] mem [DEPTH];
  logic [AW-1:0]    rdPtr;

  always_ff @(posedge Clk) begin
    mem[WrPtr] <= WrData;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rdPtr <= '0;
    end else if (RdLoad) begin
      rdPtr <= RdLoadPtr;
    end else if (RdAdv) begin
      rdPtr <= rdPtr + 1'b1;
    end
  end

  assign RdData = mem[rdPtr];

endmodule

// File: rtl/pcie_lane_deskew.sv
// Receive lane deskew: buffers every lane, locks read pointers on the first COM of each
// active lane and then emits lane-aligned symbol columns, flagging skew/alignment errors.
module pcie_lane_deskew
  import pcie_lane_pkg::*;
#(
  parameter int NUMLANES = 16,
  parameter int DEPTH    = 8
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUMLANES*SYM_W-1:0] LinkIn,
  input  logic [4:0]                LinkWidth,
  output logic [NUMLANES*SYM_W-1:0] LinkOut,
  output logic                      LinkOutValid,
  output logic                      Aligned,
  output logic                      SkewErr,
  output logic [$clog2(DEPTH)-1:0]  SkewMax
);

  localparam int         AW   = $clog2(DEPTH);
  localparam logic [4:0] MAXW = 5'(NUMLANES);

  deskewState_t state;
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] winCnt;
  logic [4:0]    widthQ;
  logic [4:0]    effWidth;
  logic [NUMLANES-1:0] seen, seenNext, activeMask, comNow, comOut;
  logic [AW-1:0] comPtr     [NUMLANES];
  logic [AW-1:0] comPtrNext [NUMLANES];
  logic [NUMLANES*SYM_W-1:0] rdBus, nextOut;
  logic allSeen, widthChg, misalign, lockNow, rdAdv;

  always_comb begin
    effWidth   = (LinkWidth == '0 || LinkWidth > MAXW) ? MAXW : LinkWidth;
    activeMask = '0;
    comNow     = '0;
    comOut     = '0;
    nextOut    = '0;
    for (int unsigned i = 0; i < NUMLANES; i++) begin
      activeMask[i] = i < 32'(effWidth);
      comNow[i]     = activeMask[i] & is_com(LinkIn[i*SYM_W +: K_BIT+1]);
      comOut[i]     = activeMask[i] & is_com(LinkOut[i*SYM_W +: K_BIT+1]);
      comPtrNext[i] = (comNow[i] && !seen[i]) ? wrPtr : comPtr[i];
      nextOut[i*SYM_W +: SYM_W] = activeMask[i] ? rdBus[i*SYM_W +: SYM_W] : '0;
    end
    seenNext = seen | comNow;
    allSeen  = (seenNext & activeMask) == activeMask;
    widthChg = effWidth != widthQ;
    misalign = LinkOutValid && comOut != '0 && comOut != activeMask;
    lockNow  = !widthChg && allSeen &&
               ((state == SEARCH && comNow != '0) || state == WINDOW);
    rdAdv    = state == ALIGNED;
  end

  for (genvar g = 0; g < NUMLANES; g++) begin : gLane
    pcie_lane_fifo #(.DEPTH(DEPTH)) uFifo (
      .Clk       (Clk),
      .Reset     (Reset),
      .WrPtr     (wrPtr),
      .WrData    (LinkIn[g*SYM_W +: SYM_W]),
      .RdLoad    (lockNow),
      .RdLoadPtr (comPtrNext[g]),
      .RdAdv     (rdAdv),
      .RdData    (rdBus[g*SYM_W +: SYM_W])
    );
  end

  // winCnt counts cycles elapsed since the first COM; the SEARCH cycle that saw it is 0.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= SEARCH;
      wrPtr        <= '0;
      winCnt       <= '0;
      widthQ       <= MAXW;
      seen         <= '0;
      comPtr       <= '{default: '0};
      LinkOut      <= '0;
      LinkOutValid <= 1'b0;
      Aligned      <= 1'b0;
      SkewErr      <= 1'b0;
      SkewMax      <= '0;
    end else begin
      wrPtr   <= wrPtr + 1'b1;
      widthQ  <= effWidth;
      SkewErr <= 1'b0;
      if (widthChg) begin
        state        <= SEARCH;
        seen         <= '0;
        LinkOut      <= '0;
        LinkOutValid <= 1'b0;
        Aligned      <= 1'b0;
        SkewMax      <= '0;
      end else begin
        case (state)
          SEARCH: begin
            if (comNow != '0) begin
              seen   <= comNow;
              comPtr <= comPtrNext;
              if (allSeen) begin
                state   <= ALIGNED;
                Aligned <= 1'b1;
                SkewMax <= '0;
              end else begin
                state  <= WINDOW;
                winCnt <= AW'(1);
              end
            end
          end
          WINDOW: begin
            seen   <= seenNext;
            comPtr <= comPtrNext;
            if (allSeen) begin
              state   <= ALIGNED;
              Aligned <= 1'b1;
              SkewMax <= winCnt;
            end else if (winCnt == AW'(DEPTH-1)) begin
              state   <= SEARCH;
              seen    <= '0;
              SkewErr <= 1'b1;
            end else begin
              winCnt <= winCnt + 1'b1;
            end
          end
          ALIGNED: begin
            if (misalign) begin
              state        <= SEARCH;
              seen         <= '0;
              SkewErr      <= 1'b1;
              LinkOut      <= '0;
              LinkOutValid <= 1'b0;
              Aligned      <= 1'b0;
              SkewMax      <= '0;
            end else begin
              LinkOut      <= nextOut;
              LinkOutValid <= 1'b1;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcie_lane_deskew.sv
// Directed bench for pcie_lane_deskew: table of skew scenarios plus hand-written corner sequences.
module tb_pcie_lane_deskew;

  localparam int NL  = 16;
  localparam int P   = 16;
  localparam int BIG = 1 << 30;

  typedef logic [NL*10+5:0] obs_t;
  typedef struct packed {
    logic [4:0]  width;
    logic        drvIn;
    logic [63:0] skews;
    logic [2:0]  span;
    logic [3:0]  dmax;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset;
  logic [NL*10-1:0] LinkIn;
  logic [4:0] LinkWidth;
  logic [NL*10-1:0] LinkOut;
  logic LinkOutValid, Aligned, SkewErr;
  logic [2:0] SkewMax;

  always #5 Clk = ~Clk;

  pcie_lane_deskew #(.NUMLANES(NL), .DEPTH(8)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .LinkIn       (LinkIn),
    .LinkWidth    (LinkWidth),
    .LinkOut      (LinkOut),
    .LinkOutValid (LinkOutValid),
    .Aligned      (Aligned),
    .SkewErr      (SkewErr),
    .SkewMax      (SkewMax)
  );

  int nVec = 0, nBad = 0, cyc = 0;
  int t0, width, span, lockC, dropC, errC;
  bit drvInactive, streamOn;
  int dly [NL];
  int lat [NL];
  logic [NL*10-1:0] hist [4096];
  vec_t tbl [7];

  function automatic int effW(input int w);
    return (w == 0 || w > NL) ? NL : w;
  endfunction

  function automatic logic [9:0] sym(input int n, input int k);
    if (k < 0) return 10'h000;
    if (k % P == 0) return 10'h1BC;
    return {2'b00, 8'(k*5 + n*29 + 1)};
  endfunction

  function automatic obs_t expAt(input int c);
    logic [NL*10-1:0] lo = '0;
    logic v = 1'b0, a = 1'b0, e = 1'b0;
    logic [2:0] sm = '0;
    if (c >= dropC) begin
      e = (c == errC);
    end else if (c >= lockC) begin
      a  = 1'b1;
      sm = 3'(span);
      v  = (c >= lockC + 1);
      if (v) for (int n = 0; n < effW(width); n++)
        lo[n*10 +: 10] = hist[(c - lat[n]) % 4096][n*10 +: 10];
    end
    return {lo, v, a, e, sm};
  endfunction

  task automatic checkObs(input string nm);
    obs_t got, want;
    got  = {LinkOut, LinkOutValid, Aligned, SkewErr, SkewMax};
    want = expAt(cyc);
    nVec++;
    if (got !== want) begin
      nBad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
    end
  endtask

  task automatic checkZero(input string nm);
    obs_t got;
    got = {LinkOut, LinkOutValid, Aligned, SkewErr, SkewMax};
    nVec++;
    if (got !== '0) begin
      nBad++;
      $display("FAIL %s cyc=%0d got=%h want=0", nm, cyc, got);
    end
  endtask

  task automatic driveCycle();
    LinkWidth = 5'(width);
    for (int n = 0; n < NL; n++)
      LinkIn[n*10 +: 10] = (streamOn && (n < effW(width) || drvInactive))
                           ? sym(n, cyc - t0 - dly[n]) : 10'h000;
    hist[cyc % 4096] = LinkIn;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic run(input string nm, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      checkObs(nm);
      driveCycle();
      step();
    end
  endtask

  task automatic resetDut(input string nm);
    Reset    = 1'b1;
    streamOn = 1'b0;
    lockC = BIG; dropC = BIG; errC = BIG;
    driveCycle();
    #1;
    checkZero(nm);
    step();
    driveCycle();
    step();
    Reset = 1'b0;
  endtask

  task automatic setupLock(input int spanH, input int dmaxH);
    span  = spanH;
    lockC = t0 + dmaxH + 1;
    dropC = BIG;
    errC  = BIG;
    for (int n = 0; n < NL; n++) lat[n] = 2 + dmaxH - dly[n];
  endtask

  task automatic startStream();
    streamOn = 1'b1;
    t0 = cyc + 3;
  endtask

  initial begin
    // {width, drive inactive lanes, per-lane skew nibbles (lane0 = LSB), SkewMax, latest skew}
    tbl[0] = '{5'd16, 1'b0, 64'h0000000000000000, 3'd0, 4'd0};
    tbl[1] = '{5'd16, 1'b0, 64'h7654321076543210, 3'd7, 4'd7};
    tbl[2] = '{5'd4,  1'b0, 64'h0000000000001302, 3'd3, 4'd3};
    tbl[3] = '{5'd8,  1'b1, 64'hCCCCCCCC44446544, 3'd2, 4'd6};
    tbl[4] = '{5'd1,  1'b1, 64'h0000000000000003, 3'd0, 4'd3};
    tbl[5] = '{5'd0,  1'b0, 64'h0210210210210210, 3'd2, 4'd2};
    tbl[6] = '{5'd20, 1'b0, 64'h0000005000000000, 3'd5, 4'd5};

    Reset = 1'b1; LinkIn = '0; width = 16; LinkWidth = 5'd16;
    drvInactive = 1'b0; streamOn = 1'b0; t0 = 0;
    for (int n = 0; n < NL; n++) dly[n] = 0;
    @(posedge Clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      width = int'(tbl[i].width);
      drvInactive = tbl[i].drvIn;
      for (int n = 0; n < NL; n++) dly[n] = int'(tbl[i].skews[n*4 +: 4]);
      resetDut($sformatf("reset%0d", i));
      startStream();
      setupLock(int'(tbl[i].span), int'(tbl[i].dmax));
      run($sformatf("vec%0d", i), 50);
    end

    // Lane 3 lags by 8: window expires once, then relock once the skew is removed.
    width = 16; drvInactive = 1'b0;
    for (int n = 0; n < NL; n++) dly[n] = 0;
    dly[3] = 8;
    resetDut("resetTo");
    startStream();
    lockC = BIG; errC = t0 + 8; dropC = t0 + 8; span = 0;
    run("timeout", 12);
    streamOn = 1'b0;
    for (int i = 0; i < 24; i++) begin driveCycle(); step(); end
    dly[3] = 0;
    startStream();
    setupLock(0, 0);
    run("relock", 30);

    // Lane 5 drops one symbol while aligned; its next COM arrives a column early.
    resetDut("resetDrop");
    startStream();
    setupLock(0, 0);
    run("dropPre", 20);
    errC = t0 + 34; dropC = t0 + 34;
    while (cyc <= t0 + 36) begin
      checkObs("drop");
      if (cyc >= t0 + 20) dly[5] = -1;
      driveCycle();
      step();
    end
    dly[5] = 0;

    // Narrow link locks on lanes 0..3 only; widening forces SEARCH without an error.
    width = 4;
    resetDut("resetW");
    startStream();
    setupLock(0, 0);
    run("width4", 25);
    checkObs("width4");
    width = 8;
    dropC = cyc + 1; errC = -1;
    driveCycle();
    step();
    run("width8", 3);

    // Reset asserted mid-cycle while aligned clears outputs at once, then relock.
    width = 16;
    resetDut("resetR");
    startStream();
    setupLock(0, 0);
    run("preReset", 25);
    #3;
    Reset = 1'b1;
    #1;
    checkZero("asyncReset");
    streamOn = 1'b0;
    step();
    driveCycle();
    step();
    Reset = 1'b0;
    startStream();
    setupLock(0, 0);
    run("postReset", 25);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
